// File: rtl/node_adder_tree_if.sv
// ---------------------------------------------------------------------------
// node_adder_tree_if
// Groups the operand-side and result-side valid/ready handshake of
// node_adder_tree.
//   in_valid  : producer -> tree, operand vector on `a` is valid
//   in_ready  : tree -> producer, vector is accepted this cycle
//   a         : producer -> tree, packed operands, operand i = a[i*WORD_WIDTH +: WORD_WIDTH]
//   out_valid : tree -> consumer, `y` holds a valid sum
//   out_ready : consumer -> tree, `y` is consumed this cycle
//   y         : tree -> consumer, full-precision sum (WORD_WIDTH+log2(NUM_INPUTS) bits)
// Modport slave is the tree's view. Modport master is the environment's view
// (producer and consumer together).
// ---------------------------------------------------------------------------
interface node_adder_tree_if #(
   parameter int WORD_WIDTH = 8,
   parameter int NUM_INPUTS = 8
);
   localparam int LEVELS    = $clog2(NUM_INPUTS);
   localparam int OUT_WIDTH = WORD_WIDTH + LEVELS;

   logic                             in_valid;
   logic                             in_ready;
   logic [NUM_INPUTS*WORD_WIDTH-1:0] a;
   logic                             out_valid;
   logic                             out_ready;
   logic [OUT_WIDTH-1:0]             y;

   modport slave  (input  in_valid, a, out_ready,
                   output in_ready, out_valid, y);
   modport master (output in_valid, a, out_ready,
                   input  in_ready, out_valid, y);
endinterface

// File: rtl/node_adder_tree.sv
// ---------------------------------------------------------------------------
// node_adder_tree
// Pipelined reduction adder. It sums NUM_INPUTS unsigned WORD_WIDTH-bit
// operands into one full-precision result. There is one register stage per
// tree level, so the latency is LEVELS = log2(NUM_INPUTS) cycles. With
// out_ready held high the throughput is one vector per clock.
// Ports:
//   clk   : single clock, rising edge
//   reset : asynchronous, active-high; clears every data and valid register
//   io    : node_adder_tree_if.slave (in_valid/in_ready/a, out_valid/out_ready/y)
// The whole pipe advances together whenever the output slot is empty or is
// being consumed. Bubbles travel through it as holes.
// ---------------------------------------------------------------------------
module node_adder_tree #(
   parameter int WORD_WIDTH = 8,
   parameter int NUM_INPUTS = 8
) (
   input  logic                 clk,
   input  logic                 reset,
   node_adder_tree_if.slave     io
);
   localparam int LEVELS = $clog2(NUM_INPUTS);

   logic adv;

   // The global advance depends only on the output register and out_ready.
   // No path runs from a or in_valid to any output.
   always_comb begin
      adv = !io.out_valid || io.out_ready;
   end

   assign io.in_ready = adv;

   for (genvar l = 1; l <= LEVELS; l++) begin : g_lvl
      localparam int IW = WORD_WIDTH + l - 1;   // node input width at this level
      localparam int OW = IW + 1;               // node output width, carry-out kept
      localparam int N  = NUM_INPUTS >> l;      // node count at this level

      logic [2*N*IW-1:0] src;
      logic              src_vld;
      logic [N*OW-1:0]   sum_d;
      logic [N*OW-1:0]   sum_q;
      logic              vld_d;
      logic              vld_q;

      // Two-input ripple node. The carry out of the top bit becomes the
      // extra result bit, so nothing can overflow at any level.
      function automatic logic [OW-1:0] ripple_add(input logic [IW-1:0] x,
                                                   input logic [IW-1:0] z);
         logic [OW-1:0] s;
         logic          c;
         c = 1'b0;
         s = '0;
         for (int b = 0; b < IW; b++) begin
            s[b] = x[b] ^ z[b] ^ c;
            c    = (x[b] & z[b]) | (c & (x[b] ^ z[b]));
         end
         s[IW] = c;
         return s;
      endfunction

      // Level 1 reads the raw operands. Deeper levels read the registers
      // one level down.
      if (l == 1) begin : g_src_in
         assign src     = io.a;
         assign src_vld = io.in_valid;
      end else begin : g_src_prev
         assign src     = g_lvl[l-1].sum_q;
         assign src_vld = g_lvl[l-1].vld_q;
      end

      always_comb begin
         sum_d = sum_q;
         vld_d = vld_q;
         if (adv) begin
            vld_d = src_vld;
            for (int j = 0; j < N; j++) begin
               sum_d[j*OW +: OW] = ripple_add(src[(2*j)*IW +: IW],
                                              src[(2*j+1)*IW +: IW]);
            end
         end
      end

      // stage boundary: level l register
      always_ff @(posedge clk or posedge reset) begin
         if (reset) begin
            sum_q <= '0;
            vld_q <= 1'b0;
         end else begin
            sum_q <= sum_d;
            vld_q <= vld_d;
         end
      end
   end

   assign io.out_valid = g_lvl[LEVELS].vld_q;
   assign io.y         = g_lvl[LEVELS].sum_q;

endmodule

// File: tb/tb_node_adder_tree.sv
// ---------------------------------------------------------------------------
// tb_node_adder_tree
// Bench for node_adder_tree. It instantiates an 8x8-bit tree and a 2x8-bit
// tree. A reference model (a FIFO of expected sums and a delay line of
// LEVELS advancing cycles) checks the 8-input instance on every falling
// edge. Directed sequences pin literal sums, latency, stall, and the
// asynchronous reset behaviour.
// ---------------------------------------------------------------------------
module tb_node_adder_tree;
   localparam int W  = 8;
   localparam int NI = 8;
   localparam int LV = 3;

   logic clk = 1'b0;
   logic reset = 1'b1;

   always #5 clk = ~clk;

   node_adder_tree_if #(.WORD_WIDTH(W), .NUM_INPUTS(NI)) io ();
   node_adder_tree_if #(.WORD_WIDTH(W), .NUM_INPUTS(2))  io2 ();

   node_adder_tree #(.WORD_WIDTH(W), .NUM_INPUTS(NI)) dut (
      .clk   (clk),
      .reset (reset),
      .io    (io)
   );

   node_adder_tree #(.WORD_WIDTH(W), .NUM_INPUTS(2)) dut2 (
      .clk   (clk),
      .reset (reset),
      .io    (io2)
   );

   int checks = 0;
   int errors = 0;

   longint sq[$];     // expected sums of accepted vectors, oldest first
   bit     hist[$];   // in_valid for the last LV advancing cycles, oldest first

   task automatic check(input string nm, input longint act, input longint exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic logic [63:0] mkvec(input int base, input int step);
      logic [63:0] v;
      for (int i = 0; i < NI; i++) v[i*W +: W] = 8'(base + step * i);
      return v;
   endfunction

   function automatic longint vec_sum(input logic [63:0] v);
      longint s = 0;
      for (int i = 0; i < NI; i++) s += longint'(v[i*W +: W]);
      return s;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Reference model and per-cycle compare on the 8-input instance.
   always @(negedge clk) begin
      if (reset) begin
         sq.delete();
         hist.delete();
         for (int i = 0; i < LV; i++) hist.push_back(1'b0);
      end else begin
         check("in_ready_rule", longint'(io.in_ready),
               longint'(!io.out_valid || io.out_ready));
         check("out_valid_latency", longint'(io.out_valid), longint'(hist[0]));
         if (io.out_valid) begin
            if (sq.size() == 0) begin
               check("unexpected_result", longint'(io.y), -1);
            end else begin
               check("y_vs_model", longint'(io.y), sq[0]);
            end
            if (io.out_ready && sq.size() != 0) void'(sq.pop_front());
         end
         if (io.in_ready) begin
            void'(hist.pop_front());
            hist.push_back(io.in_valid);
         end
         if (io.in_valid && io.in_ready) sq.push_back(vec_sum(io.a));
      end
   end

   // Single vector, out_ready=1: measures latency and checks the one-cycle pulse.
   task automatic send_one(input logic [63:0] v, input longint exp, input string nm);
      int lat;
      io.a = v;
      io.in_valid = 1'b1;
      io.out_ready = 1'b1;
      tick();
      lat = 1;
      io.in_valid = 1'b0;
      while (!io.out_valid && lat < 20) begin
         tick();
         lat++;
      end
      check({nm, "_latency"}, longint'(lat), 3);
      check({nm, "_y"}, longint'(io.y), exp);
      tick();
      check({nm, "_pulse"}, longint'(io.out_valid), 0);
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [63:0] sv [4];
      longint      lit [4];
      logic [63:0] cur;
      bit          pend;
      bit          acc;
      int          sent;
      int          wait_cyc;

      io.in_valid = 1'b0;
      io.a = '0;
      io.out_ready = 1'b1;
      io2.in_valid = 1'b0;
      io2.a = '0;
      io2.out_ready = 1'b1;

      // Reset state
      #1;
      check("rst_out_valid", longint'(io.out_valid), 0);
      check("rst_y", longint'(io.y), 0);
      check("rst_in_ready", longint'(io.in_ready), 1);
      check("rst2_out_valid", longint'(io2.out_valid), 0);
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;

      // Single vectors
      send_one(mkvec(1, 1), 36, "ones_to_eight");
      send_one(mkvec(255, 0), 2040, "all_max");
      send_one(mkvec(0, 0), 0, "all_zero");

      // Back-to-back stream of four vectors
      sv[0] = mkvec(1, 1);   lit[0] = 36;
      sv[1] = mkvec(1, 0);   lit[1] = 8;
      sv[2] = mkvec(255, 0); lit[2] = 2040;
      sv[3] = mkvec(9, 1);   lit[3] = 100;
      io.out_ready = 1'b1;
      for (int c = 0; c < 8; c++) begin
         if (c < 4) begin
            io.in_valid = 1'b1;
            io.a = sv[c];
         end else begin
            io.in_valid = 1'b0;
         end
         #1;
         if (c < 4) check("stream_in_ready", longint'(io.in_ready), 1);
         if (c < 3) check("stream_empty", longint'(io.out_valid), 0);
         if (c >= 3 && c < 7) begin
            check("stream_out_valid", longint'(io.out_valid), 1);
            check("stream_y", longint'(io.y), lit[c-3]);
         end
         if (c == 7) check("stream_tail", longint'(io.out_valid), 0);
         tick();
      end

      // Fill, stall for 5 cycles, release
      sv[0] = mkvec(1, 1);   lit[0] = 36;
      sv[1] = mkvec(2, 0);   lit[1] = 16;
      sv[2] = mkvec(10, 0);  lit[2] = 80;
      sv[3] = mkvec(255, 0); lit[3] = 2040;
      for (int c = 0; c < 13; c++) begin
         io.in_valid = (c <= 8);
         io.a = sv[(c < 3) ? c : 3];
         io.out_ready = !(c >= 3 && c <= 7);
         #1;
         if (c >= 3 && c <= 7) begin
            check("stall_in_ready", longint'(io.in_ready), 0);
            check("stall_out_valid", longint'(io.out_valid), 1);
            check("stall_y", longint'(io.y), 36);
         end
         if (c >= 8 && c <= 11) begin
            check("release_out_valid", longint'(io.out_valid), 1);
            check("release_y", longint'(io.y), lit[c-8]);
         end
         if (c == 12) check("release_tail", longint'(io.out_valid), 0);
         tick();
      end
      io.in_valid = 1'b0;
      io.out_ready = 1'b1;

      // Two-input instance: 200 + 100
      io2.a = {8'd100, 8'd200};
      io2.in_valid = 1'b1;
      io2.out_ready = 1'b1;
      tick();
      io2.in_valid = 1'b0;
      io2.out_ready = 1'b0;
      #1;
      check("n2_out_valid", longint'(io2.out_valid), 1);
      check("n2_y", longint'(io2.y), 300);
      for (int k = 0; k < 3; k++) begin
         check("n2_stall_in_ready", longint'(io2.in_ready), 0);
         tick();
         check("n2_hold_valid", longint'(io2.out_valid), 1);
         check("n2_hold_y", longint'(io2.y), 300);
      end
      io2.out_ready = 1'b1;
      #1;
      check("n2_release_in_ready", longint'(io2.in_ready), 1);
      tick();
      check("n2_consumed", longint'(io2.out_valid), 0);

      // Asynchronous reset with three vectors in flight
      sv[0] = mkvec(1, 1);
      sv[1] = mkvec(1, 0);
      sv[2] = mkvec(255, 0);
      io.out_ready = 1'b1;
      for (int c = 0; c < 3; c++) begin
         io.in_valid = 1'b1;
         io.a = sv[c];
         tick();
      end
      io.in_valid = 1'b0;
      io.out_ready = 1'b0;
      #1;
      check("prerst_out_valid", longint'(io.out_valid), 1);
      check("prerst_y", longint'(io.y), 36);
      #1;
      reset = 1'b1;
      #1;
      check("async_rst_out_valid", longint'(io.out_valid), 0);
      check("async_rst_y", longint'(io.y), 0);
      check("async_rst_in_ready", longint'(io.in_ready), 1);
      tick();
      reset = 1'b0;
      io.out_ready = 1'b1;
      io.in_valid = 1'b1;
      io.a = mkvec(3, 0);
      tick();
      io.in_valid = 1'b0;
      for (int c = 1; c <= 6; c++) begin
         check("postrst_out_valid", longint'(io.out_valid), longint'(c == 3));
         if (c == 3) check("postrst_y", longint'(io.y), 24);
         tick();
      end

      // Randomized run of 1000 vectors with random valid/ready
      sent = 0;
      pend = 1'b0;
      cur = '0;
      while (sent < 1000) begin
         if (!pend && $urandom_range(0, 9) < 7) begin
            if ($urandom_range(0, 9) == 0) begin
               cur = mkvec(255, 0);
            end else begin
               for (int i = 0; i < NI; i++) cur[i*W +: W] = 8'($urandom_range(0, 255));
            end
            pend = 1'b1;
         end
         io.in_valid = pend;
         io.a = pend ? cur : {$urandom, $urandom};
         io.out_ready = ($urandom_range(0, 9) < 7);
         @(negedge clk);
         acc = io.in_valid && io.in_ready;
         tick();
         if (acc) begin
            sent++;
            pend = 1'b0;
         end
      end
      io.in_valid = 1'b0;
      io.out_ready = 1'b1;
      wait_cyc = 0;
      while (sq.size() != 0 && wait_cyc < 20) begin
         tick();
         wait_cyc++;
      end
      check("drain_empty", longint'(sq.size()), 0);
      tick();
      check("drain_idle", longint'(io.out_valid), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/node_adder_tree.md
# node_adder_tree

Pipelined, parametrised reduction adder that sums NUM_INPUTS unsigned words of WORD_WIDTH bits into one full-precision result, with one register stage per tree level and valid/ready flow control on both sides. It is the multi-operand successor to the two-operand ripple node adder. It sits between operand producers (the redundancy datapath) and any consumer that needs the reduced sum at one result per clock. Each tree node is a two-input ripple adder of the current level's width, producing a result one bit wider.

## Interface
- WORD_WIDTH, 8, width of each input operand (≥1)
- NUM_INPUTS, 8, number of operands; power of two, ≥2
- LEVELS (localparam), log2(NUM_INPUTS), tree depth and pipeline latency
- OUT_WIDTH (localparam), WORD_WIDTH+LEVELS, result width
- clk  input  1  single clock, all state on rising edge
- reset  input  1  asynchronous, active-high; clears all state immediately
- in_valid  input  1  operand vector on `a` is valid
- in_ready  output  1  block accepts the vector this cycle
- a  input  NUM_INPUTS*WORD_WIDTH  packed operands; operand i = a[i*WORD_WIDTH +: WORD_WIDTH]
- out_valid  output  1  `y` holds a valid sum
- out_ready  input  1  consumer accepts `y` this cycle
- y  output  OUT_WIDTH  registered sum of one accepted vector

## Operation
- Level l (1..LEVELS) has NUM_INPUTS>>l registered sums of width WORD_WIDTH+l, plus one valid bit vld[l].
- Node j of level l = node 2j + node 2j+1 of level l-1, zero-extended sum with carry-out kept. Level 0 is the unregistered input operands.
- Arithmetic is unsigned. No overflow is possible: OUT_WIDTH holds NUM_INPUTS*(2^WORD_WIDTH-1).
- y = level LEVELS register; out_valid = vld[LEVELS].
- Global advance: adv = !out_valid || out_ready. in_ready = adv (combinational).
- On adv, every level loads from the level below. vld[1] <= in_valid, vld[l] <= vld[l-1].
- When adv=0, all data and valid registers hold.
- Bubbles (invalid slots) propagate as holes. They are not collapsed. Data registers of invalid slots may load anything, but y is only meaningful when out_valid=1.
- A vector is accepted iff in_valid && in_ready. A result is consumed iff out_valid && out_ready.
- Ordering is strictly FIFO. No vector is dropped or duplicated.
- in_valid with in_ready=0: `a` is not sampled. The producer must hold it (standard valid/ready).
- Reset behaviour:
  - Asserting reset, including mid-stream, asynchronously clears all vld bits and data registers: out_valid=0, y=0, in_ready=1.
  - In-flight vectors are discarded.
  - First acceptance is possible on the first rising edge after reset deasserts.

## Timing
- Latency: a vector accepted at edge k appears with out_valid=1 after edge k+LEVELS-1, i.e. LEVELS cycles after it was presented, when no stall occurs.
- Throughput: one vector per cycle while out_ready=1.
- Stall: out_valid=1 and out_ready=0 gives in_ready=0 in the same cycle. y and out_valid stay stable until consumed.
- Simultaneous consume and accept (out_valid && out_ready && in_valid) advances the pipe with no bubble.
- Combinational paths:
  - out_ready → in_ready.
  - Each level's critical path is one ripple adder of WORD_WIDTH+l-1 bits.
  - a → first register.
  - No path from a or in_valid to any output.

## Test plan
- WORD_WIDTH=8, NUM_INPUTS=8: present operands 1..8 once, out_ready=1 → out_valid after 3 cycles, y=36 (11-bit), pulse exactly 1 cycle.
- Same config, all operands 255 → y=2040. All operands 0 → y=0 with out_valid=1.
- Stream 4 vectors back-to-back (sums 36, 8, 2040, 100), out_ready=1 → results on 4 consecutive cycles, in order, in_ready constantly 1.
- Fill the pipe, hold out_ready=0 for 5 cycles:
  - in_ready=0, y frozen at the first sum.
  - Release: remaining results emerge in order, none lost or duplicated.
  - Random in_valid/out_ready scoreboard run of 1000 vectors passes.
- Assert reset asynchronously (between edges) with 3 vectors in flight → out_valid and y go to 0 before the next edge. After release, only post-reset vectors appear.
- WORD_WIDTH=8, NUM_INPUTS=2: operands 200 and 100 → y=300 (9-bit) after 1 cycle. out_ready=0 stalls and holds 300.
